// File: rtl/clk_div_multi_pkg.sv
// Shared types and default sizing for the multi-channel tick/clock-enable generator.
package clk_div_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2
  } clk_mode_t;

  localparam int unsigned CNT_W_DEF        = 26;
  localparam int unsigned DEBOUNCE_CYC_DEF = 1_000_000;

endpackage

// File: rtl/clk_div_multi_step_debounce.sv
// Step push-button conditioner: two-flop synchroniser, optional stable-count
// filter (CLKDIV_DEBOUNCE_EN), rising-edge detector with a registered one-cycle
// step_pulse output.
module step_debounce
  import clk_div_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic step_btn,
  output logic step_pulse
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
    end
  end

`ifdef CLKDIV_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DB_W-1:0] stable_cnt;

  // Accept a new level only after it has differed for DEBOUNCE_CYC cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DB_LAST) begin
      level      <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + DB_W'(1);
    end
  end
`else
  assign level = sync2;
`endif

  // Rising-edge detect on the accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d    <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      level_d    <= level;
      step_pulse <= level & ~level_d;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable tick / 50%-duty toggle generator with HALT, RUN
// and single-STEP modes. Step-button filtering is enabled by CLKDIV_DEBOUNCE_EN.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    step_btn,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  output logic [NUM_CH-1:0]       tick_out,
  output logic [NUM_CH-1:0]       clk_out
);

  clk_mode_t mode_next;
  clk_mode_t mode_q;
  logic      run_entry;
  logic      step_pulse;
  logic      step_fire;

  // Decode the requested mode; the encoding 3 behaves as HALT
  always_comb begin
    mode_next = MODE_HALT;
    case (mode)
      2'd1:    mode_next = MODE_RUN;
      2'd2:    mode_next = MODE_STEP;
      default: mode_next = MODE_HALT;
    endcase
  end

  // The new mode governs the edge it arrives on
  always_comb begin
    run_entry = 1'b0;
    step_fire = 1'b0;
    run_entry = (mode_next == MODE_RUN) && (mode_q != MODE_RUN);
    step_fire = (mode_next == MODE_STEP) && step_pulse;
  end

  // Mode register, used to spot entry into RUN
  always_ff @(posedge clk_in) begin
    if (reset) begin
      mode_q <= MODE_HALT;
    end else begin
      mode_q <= mode_next;
    end
  end

  step_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_step (
    .clk       (clk_in),
    .reset     (reset),
    .step_btn  (step_btn),
    .step_pulse(step_pulse)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] last;
    logic             term;
    logic             tick_q;
    logic             tog_q;

    assign div = div_val[ch*CNT_W +: CNT_W];

    // Terminal compare; shadow values 0 and 1 end the period every cycle
    always_comb begin
      last = '0;
      if (shadow != '0) begin
        last = shadow - CNT_W'(1);
      end
      term = (cnt == last);
    end

    // Per-channel counter, shadow divisor, tick pulse and toggle
    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt    <= '0;
        shadow <= div;
        tick_q <= 1'b0;
        tog_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        case (mode_next)
          MODE_RUN: begin
            if (run_entry) begin
              cnt <= '0;
            end else if (term) begin
              cnt    <= '0;
              shadow <= div;
              tick_q <= enable;
              tog_q  <= tog_q ^ enable;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          MODE_STEP: begin
            cnt    <= '0;
            tick_q <= step_fire;
            tog_q  <= tog_q ^ step_fire;
          end
          default: begin
            cnt <= cnt;
          end
        endcase
      end
    end

    assign tick_out[ch] = tick_q;
    assign clk_out[ch]  = tog_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi (default build, no step debounce):
// directed scenarios plus randomized mode/enable/button/divisor traffic, all
// compared every cycle against a cycle-count reference model.
module tb_clk_div_multi;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 26;

  logic                    clk_in = 1'b0;
  logic                    reset;
  logic                    enable;
  logic [1:0]              mode;
  logic                    step_btn;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       tick_out;
  logic [NUM_CH-1:0]       clk_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int                elapsed [NUM_CH];
  int                period  [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_clk;
  int                m_prev;
  logic [4:0]        hist;

  // Directed-scenario tallies of observed DUT ticks
  int tick_cnt [NUM_CH];
  int first_at [NUM_CH];

  clk_div_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .enable  (enable),
    .mode    (mode),
    .step_btn(step_btn),
    .div_val (div_val),
    .tick_out(tick_out),
    .clk_out (clk_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int div_of(input int ch);
    return int'(32'(div_val[ch*CNT_W +: CNT_W]));
  endfunction

  function automatic logic [NUM_CH*CNT_W-1:0] pack_div(input int d0, input int d1);
    return {CNT_W'(d1), CNT_W'(d0)};
  endfunction

  // Model: a channel ticks once `elapsed` edges since its period start reach
  // the latched period (min 1); step ticks come 3 edges after a sampled rise.
  task automatic model_update();
    logic fire;
    int   m;
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        elapsed[ch] = 0;
        period[ch]  = div_of(ch);
      end
      m_tick = '0;
      m_clk  = '0;
      m_prev = 0;
      hist   = '0;
    end else begin
      hist = {hist[3:0], step_btn};
      fire = hist[3] & ~hist[4];
      m    = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_tick[ch] = 1'b0;
        if (m == 1) begin
          if (m_prev != 1) begin
            elapsed[ch] = 0;
          end else begin
            elapsed[ch] = elapsed[ch] + 1;
            if (elapsed[ch] >= ((period[ch] < 2) ? 1 : period[ch])) begin
              elapsed[ch] = 0;
              period[ch]  = div_of(ch);
              m_tick[ch]  = enable;
              m_clk[ch]   = m_clk[ch] ^ enable;
            end
          end
        end else if (m == 2) begin
          elapsed[ch] = 0;
          m_tick[ch]  = fire;
          m_clk[ch]   = m_clk[ch] ^ fire;
        end
      end
      m_prev = m;
    end
  endtask

  task automatic tick_edge();
    @(posedge clk_in);
    model_update();
    #1;
    check("tick_out", 32'(tick_out), 32'(m_tick));
    check("clk_out", 32'(clk_out), 32'(m_clk));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_edge();
  endtask

  task automatic run_count(input int n);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      tick_cnt[ch] = 0;
      first_at[ch] = 0;
    end
    for (int i = 1; i <= n; i++) begin
      tick_edge();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (tick_out[ch] === 1'b1) begin
          tick_cnt[ch]++;
          if (first_at[ch] == 0) first_at[ch] = i;
        end
      end
    end
  endtask

  // Reset for two edges, then the RUN-entry edge (counter cleared there)
  task automatic reset_then_run(input int d0, input int d1);
    reset   = 1'b1;
    mode    = 2'd0;
    div_val = pack_div(d0, d1);
    run(2);
    check("reset_tick", 32'(tick_out), 32'd0);
    check("reset_clk", 32'(clk_out), 32'd0);
    reset = 1'b0;
    mode  = 2'd1;
    tick_edge();
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    mode     = 2'd0;
    step_btn = 1'b0;
    div_val  = pack_div(4, 6);

    // Divisors {4,6}: ticks at 4,8,12 and 6,12
    reset_then_run(4, 6);
    run_count(12);
    check("a_cnt0", 32'(tick_cnt[0]), 32'd3);
    check("a_cnt1", 32'(tick_cnt[1]), 32'd2);
    check("a_first0", 32'(first_at[0]), 32'd4);
    check("a_first1", 32'(first_at[1]), 32'd6);
    check("a_clk", 32'(clk_out), 32'b01);

    // ch0 divisor 4 -> 10 after cycle 6: ticks at 8, 18, 28
    reset_then_run(4, 4);
    run_count(6);
    div_val = pack_div(10, 4);
    run_count(22);
    check("b_cnt0", 32'(tick_cnt[0]), 32'd3);
    check("b_first0", 32'(first_at[0]), 32'd2);

    // enable low for cycles 5..9: tick at 8 lost, tick at 12 kept
    reset_then_run(4, 4);
    run(4);
    enable = 1'b0;
    run_count(5);
    check("c_cnt_off", 32'(tick_cnt[0]), 32'd0);
    check("c_clk_hold", 32'(clk_out), 32'b11);
    enable = 1'b1;
    run_count(3);
    check("c_cnt_on", 32'(tick_cnt[0]), 32'd1);
    check("c_first", 32'(first_at[0]), 32'd3);

    // STEP: 20-cycle press gives one tick 3 edges after first sample
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    mode  = 2'd2;
    run(3);
    step_btn = 1'b1;
    run_count(20);
    check("d_cnt0", 32'(tick_cnt[0]), 32'd1);
    check("d_cnt1", 32'(tick_cnt[1]), 32'd1);
    check("d_first", 32'(first_at[0]), 32'd4);
    check("d_clk", 32'(clk_out), 32'b11);
    step_btn = 1'b0;
    run(5);

    // Divisors 0 and 1 tick every cycle
    reset_then_run(0, 1);
    run_count(10);
    check("e_cnt0", 32'(tick_cnt[0]), 32'd10);
    check("e_cnt1", 32'(tick_cnt[1]), 32'd10);

    // Reset mid-run clears outputs on the next edge
    div_val = pack_div(3, 5);
    reset_then_run(3, 5);
    run(7);
    reset = 1'b1;
    tick_edge();
    check("f_tick", 32'(tick_out), 32'd0);
    check("f_clk", 32'(clk_out), 32'd0);
    reset = 1'b0;

    // Randomized traffic
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      mode = 2'($urandom_range(0, 3));
      len  = int'($urandom_range(4, 30));
      if ($urandom_range(0, 3) == 0) div_val = pack_div($urandom_range(0, 9), $urandom_range(0, 9));
      for (int i = 0; i < len; i++) begin
        reset = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 7) == 0) enable = ~enable;
        if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
        if ($urandom_range(0, 19) == 0) div_val = pack_div($urandom_range(0, 9), $urandom_range(0, 9));
        tick_edge();
      end
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable tick and clock-enable generator. It derives NUM_CH independent slow ticks and 50 %-duty toggles from the board clock. Each channel's divisor can be changed at run time, and a global mode selects halt, free-run or single-step. It sits between the board clock and the processor's clocking and display logic, and provides run/step control for bring-up and debug.

## Interface
- NUM_CH, 2: number of independent divider channels (1..8).
- CNT_W, 26: counter and divisor width.
- DEBOUNCE_CYC, 1_000_000: stable-cycles requirement for step input; used only when CLKDIV_DEBOUNCE_EN is defined.
- clk_in  input  1  board clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global tick/toggle enable (RUN mode only).
- mode  input  2  0 HALT, 1 RUN, 2 STEP; 3 is treated as HALT.
- step_btn  input  1  asynchronous single-step request (push button).
- div_val  input  NUM_CH×CNT_W  per-channel divisor D; values 0 and 1 both mean "tick every cycle".
- tick_out  output  NUM_CH  one-cycle pulse per channel period (registered).
- clk_out  output  NUM_CH  per-channel toggle, flips on every tick (registered).

## Operation
- Reset (reset=1 at an edge) has the following effects:
  - Counters are cleared to 0.
  - tick_out is driven to 0 and clk_out to 0.
  - Shadow divisors are loaded from div_val.
  - Synchroniser and edge-detect flops are cleared.
  - The mode register is set to HALT.
- The mode register samples `mode` every cycle. On a transition into RUN, all counters are cleared to 0 on that edge.
- RUN behaviour, per channel:
  - The counter increments every cycle.
  - When the counter equals shadow−1 (terminal), it returns to 0 and the shadow reloads from div_val.
  - If enable=1, the terminal cycle also sets tick_out=1 for the next cycle and inverts clk_out.
  - If enable=0, the counter still runs, but tick_out stays 0 and clk_out holds.
- Divisor changes take effect only at a terminal count, so no runt periods occur. A shadow value ≤1 makes the terminal count true every cycle.
- HALT behaviour: counters hold their value, tick_out=0, and clk_out holds.
- STEP behaviour:
  - Counters are forced to 0.
  - Each qualified rising edge of step_btn produces exactly one tick_out pulse on all channels simultaneously and inverts every clk_out.
  - enable is ignored in STEP.
- The step path consists of a two-flop synchroniser followed by a rising-edge detector. Edges that occur outside STEP mode are discarded, not queued.
- Width rules:
  - The counter is CNT_W bits wide.
  - shadow−1 is computed in CNT_W bits, with 0 mapped to 0.
  - Wrap-around of the counter can only occur via terminal count.

## Timing
- All outputs are registered, and there is no combinational path from input to output.
- RUN with divisor D ≥ 2, starting from counter 0:
  - tick_out is high during cycles D, 2D, 3D, … after the edge that cleared the counter.
  - clk_out period is 2D cycles.
- STEP without debounce: tick_out is high for exactly one cycle, starting 3 edges after the first edge that samples step_btn=1.
- Holding step_btn high produces one tick only.
- Reset asserted mid-period or mid-step aborts the operation immediately. A pending step edge is lost.
- If a mode change and a terminal count occur on the same edge, the new mode wins:
  - Leaving RUN suppresses that tick.
  - Entering RUN clears the counter.

## Configuration
- CLKDIV_DEBOUNCE_EN defined:
  - The synchronised step_btn must stay stable for DEBOUNCE_CYC consecutive cycles before its level is accepted.
  - The step latency becomes 3 + DEBOUNCE_CYC cycles.
  - Bounces shorter than DEBOUNCE_CYC produce no tick.
- Not defined: there is no filter; the debounce logic and the DEBOUNCE_CYC parameter are unused. Every clean synchronised rising edge in STEP gives one tick.

## Structure
- The shared package `clk_div_pkg` holds:
  - the typedef enum logic [1:0] clk_mode_t {MODE_HALT, MODE_RUN, MODE_STEP};
  - the default CNT_W constant;
  - the default DEBOUNCE_CYC constant.
- One sub-module, `step_debounce` (synchroniser plus optional stable-count filter plus rising-edge detect). It outputs a one-cycle step_pulse.
- The channel logic is a generate loop over NUM_CH inside clk_div_multi.

## Test plan
- Reset, RUN, enable=1, NUM_CH=2, div_val={4,6}: ch0 tick_out at cycles 4, 8, 12 and clk_out period 8; ch1 tick_out at cycles 6, 12 and clk_out period 12.
- RUN, ch0 div_val changes from 4 to 10 at cycle 6: the next tick is at 8, then at 18 and 28; there is no tick at 12.
- RUN, enable dropped for cycles 5–9 with D=4: no tick at 8 and clk_out holds; a tick occurs at 12 (counter kept running).
- STEP, step_btn high for 20 cycles, no debounce: one tick on both channels exactly 3 cycles after the first high sample; both clk_out invert once; counters stay at 0.
- With CLKDIV_DEBOUNCE_EN and DEBOUNCE_CYC=8: a 5-cycle glitch produces no tick; a 12-cycle press produces one tick at 3+8 cycles.
- div_val=0 and div_val=1: tick_out is high every cycle in RUN. Reset asserted mid-run clears the outputs to 0 on the next edge.
